// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, scalar ALU opcodes and vector sequencer states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: accepts one vector op, streams its lanes one per cycle
// through an external scalar ALU, collects the per-lane results and flags, and
// holds the result vector until the consumer takes it.
module vector_alu_sequencer
  import cpu_types_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               req_valid,
  output logic               req_ready,
  input  aluop_t             req_op,
  input  word_t              req_porta [THREADS],
  input  word_t              req_portb [THREADS],
  input  logic [THREADS-1:0] req_mask,
  output word_t              alu_porta,
  output word_t              alu_portb,
  output aluop_t             alu_op,
  input  word_t              alu_out,
  input  logic               alu_nf,
  input  logic               alu_zf,
  input  logic               alu_of,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output word_t              rsp_out [THREADS],
  output logic [THREADS-1:0] rsp_nf,
  output logic [THREADS-1:0] rsp_zf,
  output logic [THREADS-1:0] rsp_of
);

  localparam int IW = $clog2(THREADS);
  typedef logic [IW-1:0] idx_t;

  seq_state_t         state_q, state_d;
  idx_t               idx_q;
  aluop_t             op_q;
  word_t              porta_q [THREADS];
  word_t              portb_q [THREADS];
  logic [THREADS-1:0] mask_q;
  word_t              out_q [THREADS];
  logic [THREADS-1:0] nf_q, zf_q, of_q;
  logic               valid_q;
  logic               accept;

  assign accept = req_valid && req_ready;

  // State register; reset aborts any op in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, request handshake and scalar ALU drive (ALU bus is quiet outside ISSUE).
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    alu_porta = '0;
    alu_portb = '0;
    alu_op    = aluop_t'('0);
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (req_mask != '0) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        alu_porta = porta_q[idx_q];
        alu_portb = portb_q[idx_q];
        alu_op    = op_q;
        if (idx_q == idx_t'(THREADS - 1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and per-lane result collection; every lane is visited even when masked off.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idx_q   <= '0;
      op_q    <= aluop_t'('0);
      mask_q  <= '0;
      nf_q    <= '0;
      zf_q    <= '0;
      of_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < THREADS; i++) begin
        porta_q[i] <= '0;
        portb_q[i] <= '0;
        out_q[i]   <= '0;
      end
    end else begin
      valid_q <= (state_d == RESP);
      if (accept) begin
        idx_q  <= '0;
        op_q   <= req_op;
        mask_q <= req_mask;
        nf_q   <= '0;
        zf_q   <= '0;
        of_q   <= '0;
        for (int i = 0; i < THREADS; i++) begin
          porta_q[i] <= req_porta[i];
          portb_q[i] <= req_portb[i];
          out_q[i]   <= '0;
        end
      end else if (state_q == ISSUE) begin
        idx_q <= idx_q + idx_t'(1);
        if (mask_q[idx_q]) begin
          out_q[idx_q] <= alu_out;
          nf_q[idx_q]  <= alu_nf;
          zf_q[idx_q]  <= alu_zf;
          of_q[idx_q]  <= alu_of;
        end else begin
          out_q[idx_q] <= '0;
          nf_q[idx_q]  <= 1'b0;
          zf_q[idx_q]  <= 1'b0;
          of_q[idx_q]  <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_out   = out_q;
  assign rsp_nf    = nf_q;
  assign rsp_zf    = zf_q;
  assign rsp_of    = of_q;

endmodule
